// File: rtl/atm_pin_if.sv
// Keypad/session bus between the ATM transaction logic and the PIN controller.
// The slave modport is the controller's view, the master modport drives it.
interface atm_pin_if;
    logic        tarjeta_recibida;
    logic        add_digit;
    logic [3:0]  digito;
    logic        digito_stb;
    logic        fin_sesion;
    logic [15:0] pin_ref;
    logic        pin_ok;
    logic        pin_incorrecto;
    logic        advertencia;
    logic        bloqueo;
    logic [2:0]  digit_count;
    logic        tiempo_agotado;

    modport slave (
        input  tarjeta_recibida, add_digit, digito, digito_stb, fin_sesion, pin_ref,
        output pin_ok, pin_incorrecto, advertencia, bloqueo, digit_count, tiempo_agotado
    );

    modport master (
        output tarjeta_recibida, add_digit, digito, digito_stb, fin_sesion, pin_ref,
        input  pin_ok, pin_incorrecto, advertencia, bloqueo, digit_count, tiempo_agotado
    );
endinterface

// File: rtl/atm_pin_ctrl.sv
// ATM PIN entry controller: collects four BCD digits, checks them, and locks after three failures.
// Define PIN_TIMEOUT_EN to enable the 255-cycle inactivity timeout while collecting digits.
module atm_pin_ctrl (
    input  logic       clk,
    input  logic       rst,
    atm_pin_if.slave   bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] COLLECT = 3'd1;
    localparam logic [2:0] CHECK   = 3'd2;
    localparam logic [2:0] GRANTED = 3'd3;
    localparam logic [2:0] LOCKED  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [15:0] buf_q, buf_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  att_q, att_d;
    logic        add_q;
    logic        ok_q, ok_d;
    logic        inc_q, inc_d;
    logic        adv_q, adv_d;
    logic        bloq_q, bloq_d;
    logic        digit_edge;
    logic        accept;
    logic        fail;
`ifdef PIN_TIMEOUT_EN
    logic [7:0]  tmr_q, tmr_d;
    logic        to_q, to_d;
`endif

    assign digit_edge = bus.add_digit & ~add_q;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        att_d   = att_q;
        ok_d    = 1'b0;
        inc_d   = 1'b0;
        adv_d   = adv_q;
        bloq_d  = bloq_q;
        accept  = 1'b0;
        fail    = 1'b0;
`ifdef PIN_TIMEOUT_EN
        tmr_d   = 8'd0;
        to_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.tarjeta_recibida) begin
                    state_d = COLLECT;
                    buf_d   = 16'd0;
                    cnt_d   = 3'd0;
                    att_d   = 2'd0;
                    adv_d   = 1'b0;
                end
            end
            COLLECT: begin
                // Enter has priority over a simultaneous digit edge.
                if (bus.digito_stb) begin
                    if (cnt_q == 3'd4) state_d = CHECK;
                    else               fail    = 1'b1;
                end else if (digit_edge && (cnt_q != 3'd4)) begin
                    accept = 1'b1;
                    buf_d  = {buf_q[11:0], bus.digito};
                    cnt_d  = cnt_q + 3'd1;
                end
`ifdef PIN_TIMEOUT_EN
                if (!(bus.digito_stb || accept)) begin
                    if (tmr_q == 8'd255) begin
                        to_d    = 1'b1;
                        state_d = IDLE;
                        buf_d   = 16'd0;
                        cnt_d   = 3'd0;
                        att_d   = 2'd0;
                        adv_d   = 1'b0;
                    end else begin
                        tmr_d = tmr_q + 8'd1;
                    end
                end
`endif
            end
            CHECK: begin
                if (buf_q == bus.pin_ref) begin
                    ok_d    = 1'b1;
                    state_d = GRANTED;
                end else begin
                    fail = 1'b1;
                end
            end
            GRANTED: begin
                if (bus.fin_sesion) begin
                    state_d = IDLE;
                    buf_d   = 16'd0;
                    cnt_d   = 3'd0;
                    adv_d   = 1'b0;
                end
            end
            LOCKED: ;
            default: state_d = IDLE;
        endcase

        // Shared failure path for a short entry and a wrong PIN.
        if (fail) begin
            inc_d = 1'b1;
            buf_d = 16'd0;
            cnt_d = 3'd0;
            att_d = (att_q == 2'd3) ? 2'd3 : att_q + 2'd1;
            if (att_q == 2'd1) adv_d = 1'b1;
            if (att_q >= 2'd2) begin
                state_d = LOCKED;
                bloq_d  = 1'b1;
            end else begin
                state_d = COLLECT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            buf_q   <= 16'd0;
            cnt_q   <= 3'd0;
            att_q   <= 2'd0;
            add_q   <= 1'b0;
            ok_q    <= 1'b0;
            inc_q   <= 1'b0;
            adv_q   <= 1'b0;
            bloq_q  <= 1'b0;
`ifdef PIN_TIMEOUT_EN
            tmr_q   <= 8'd0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            att_q   <= att_d;
            add_q   <= bus.add_digit;
            ok_q    <= ok_d;
            inc_q   <= inc_d;
            adv_q   <= adv_d;
            bloq_q  <= bloq_d;
`ifdef PIN_TIMEOUT_EN
            tmr_q   <= tmr_d;
            to_q    <= to_d;
`endif
        end
    end

    assign bus.pin_ok         = ok_q;
    assign bus.pin_incorrecto = inc_q;
    assign bus.advertencia    = adv_q;
    assign bus.bloqueo        = bloq_q;
    assign bus.digit_count    = cnt_q;
`ifdef PIN_TIMEOUT_EN
    assign bus.tiempo_agotado = to_q;
`else
    assign bus.tiempo_agotado = 1'b0;
`endif
endmodule

// File: tb/tb_atm_pin_ctrl.sv
// Directed testbench for atm_pin_ctrl: correct PIN, short entry, extra digit, lockout,
// asynchronous reset while locked, enter/digit collision and the optional timeout.
module tb_atm_pin_ctrl;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_GRANTED = 3'd3;
    localparam logic [2:0] S_LOCKED  = 3'd4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    atm_pin_if bus ();
    atm_pin_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic insert_card();
        @(negedge clk) bus.tarjeta_recibida = 1'b1;
        @(negedge clk) bus.tarjeta_recibida = 1'b0;
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clk);
        bus.add_digit = 1'b1;
        bus.digito    = d;
        repeat (2) @(negedge clk);
        bus.add_digit = 1'b0;
    endtask

    task automatic enter_pin(input logic [15:0] p);
        press(p[15:12]); press(p[11:8]); press(p[7:4]); press(p[3:0]);
    endtask

    // Returns on the falling edge just after the clock edge that sampled enter.
    task automatic press_stb();
        @(negedge clk) bus.digito_stb = 1'b1;
        @(negedge clk) bus.digito_stb = 1'b0;
    endtask

    task automatic test_reset();
        bus.tarjeta_recibida = 1'b1;
        bus.add_digit = 1'b1;
        bus.digito_stb = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.pin_ok !== 1'b0) begin n_fail++; $display("FAIL reset_pin_ok: got %b expected 0", bus.pin_ok); end
        n_checks++; if (bus.bloqueo !== 1'b0 || bus.advertencia !== 1'b0 || bus.pin_incorrecto !== 1'b0 || bus.tiempo_agotado !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b%b%b%b expected 0000", bus.bloqueo, bus.advertencia, bus.pin_incorrecto, bus.tiempo_agotado); end
        n_checks++; if (bus.digit_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.digit_count); end
        n_checks++; if (dut.state_q !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, S_IDLE); end
        bus.tarjeta_recibida = 1'b0;
        bus.add_digit = 1'b0;
        bus.digito_stb = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_correct_pin();
        do_reset();
        insert_card();
        n_checks++; if (dut.state_q !== S_COLLECT) begin n_fail++; $display("FAIL card_state: got %0d expected %0d", dut.state_q, S_COLLECT); end
        enter_pin(16'h4756);
        @(negedge clk);
        n_checks++; if (bus.digit_count !== 3'd4) begin n_fail++; $display("FAIL ok_count: got %0d expected 4", bus.digit_count); end
        press_stb();
        n_checks++; if (bus.pin_ok !== 1'b0 || bus.pin_incorrecto !== 1'b0) begin n_fail++; $display("FAIL ok_check_cycle: got ok=%b inc=%b expected 0 0", bus.pin_ok, bus.pin_incorrecto); end
        @(negedge clk);
        n_checks++; if (bus.pin_ok !== 1'b1 || bus.pin_incorrecto !== 1'b0) begin n_fail++; $display("FAIL ok_pulse: got ok=%b inc=%b expected 1 0", bus.pin_ok, bus.pin_incorrecto); end
        n_checks++; if (dut.state_q !== S_GRANTED) begin n_fail++; $display("FAIL ok_state: got %0d expected %0d", dut.state_q, S_GRANTED); end
        @(negedge clk);
        n_checks++; if (bus.pin_ok !== 1'b0) begin n_fail++; $display("FAIL ok_pulse_width: got %b expected 0", bus.pin_ok); end
        @(negedge clk) bus.fin_sesion = 1'b1;
        @(negedge clk) bus.fin_sesion = 1'b0;
        n_checks++; if (dut.state_q !== S_IDLE) begin n_fail++; $display("FAIL fin_state: got %0d expected %0d", dut.state_q, S_IDLE); end
        $display("test_correct_pin done");
    endtask

    task automatic test_fifth_digit();
        do_reset();
        insert_card();
        enter_pin(16'h4756);
        press(4'h9);
        @(negedge clk);
        n_checks++; if (bus.digit_count !== 3'd4) begin n_fail++; $display("FAIL fifth_count: got %0d expected 4", bus.digit_count); end
        press_stb();
        @(negedge clk);
        n_checks++; if (bus.pin_ok !== 1'b1) begin n_fail++; $display("FAIL fifth_pin_ok: got %b expected 1", bus.pin_ok); end
        $display("test_fifth_digit done");
    endtask

    task automatic test_short_entry();
        do_reset();
        insert_card();
        press(4'h4); press(4'h7);
        @(negedge clk);
        n_checks++; if (bus.digit_count !== 3'd2) begin n_fail++; $display("FAIL short_count_before: got %0d expected 2", bus.digit_count); end
        press_stb();
        n_checks++; if (bus.pin_incorrecto !== 1'b1) begin n_fail++; $display("FAIL short_inc: got %b expected 1", bus.pin_incorrecto); end
        n_checks++; if (bus.digit_count !== 3'd0) begin n_fail++; $display("FAIL short_count: got %0d expected 0", bus.digit_count); end
        n_checks++; if (dut.state_q !== S_COLLECT) begin n_fail++; $display("FAIL short_state: got %0d expected %0d", dut.state_q, S_COLLECT); end
        @(negedge clk);
        n_checks++; if (bus.pin_incorrecto !== 1'b0) begin n_fail++; $display("FAIL short_inc_width: got %b expected 0", bus.pin_incorrecto); end
        $display("test_short_entry done");
    endtask

    task automatic test_stb_wins();
        do_reset();
        insert_card();
        press(4'h4); press(4'h7); press(4'h5);
        @(negedge clk);
        bus.add_digit  = 1'b1;
        bus.digito     = 4'h6;
        bus.digito_stb = 1'b1;
        @(negedge clk);
        bus.add_digit  = 1'b0;
        bus.digito_stb = 1'b0;
        n_checks++; if (bus.pin_incorrecto !== 1'b1 || bus.digit_count !== 3'd0) begin n_fail++; $display("FAIL stb_wins: got inc=%b count=%0d expected 1 0", bus.pin_incorrecto, bus.digit_count); end
        $display("test_stb_wins done");
    endtask

    task automatic test_lockout();
        do_reset();
        insert_card();
        for (int i = 0; i < 3; i++) begin
            enter_pin(16'h1234);
            press_stb();
            @(negedge clk);
            n_checks++; if (bus.pin_incorrecto !== 1'b1) begin n_fail++; $display("FAIL lock_inc_%0d: got %b expected 1", i, bus.pin_incorrecto); end
            n_checks++; if (bus.advertencia !== (i >= 1)) begin n_fail++; $display("FAIL lock_adv_%0d: got %b expected %b", i, bus.advertencia, (i >= 1)); end
            n_checks++; if (bus.bloqueo !== (i == 2)) begin n_fail++; $display("FAIL lock_bloq_%0d: got %b expected %b", i, bus.bloqueo, (i == 2)); end
            @(negedge clk);
            n_checks++; if (bus.pin_incorrecto !== 1'b0) begin n_fail++; $display("FAIL lock_inc_width_%0d: got %b expected 0", i, bus.pin_incorrecto); end
        end
        enter_pin(16'h4756);
        press_stb();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (bus.pin_ok !== 1'b0) begin n_fail++; $display("FAIL locked_pin_ok_%0d: got %b expected 0", i, bus.pin_ok); end
        end
        n_checks++; if (bus.bloqueo !== 1'b1 || dut.state_q !== S_LOCKED) begin n_fail++; $display("FAIL locked_hold: got bloq=%b state=%0d expected 1 %0d", bus.bloqueo, dut.state_q, S_LOCKED); end
        $display("test_lockout done");
    endtask

    // Reset asserted a few ns after a rising edge must take effect before the next one.
    task automatic test_reset_locked();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++; if (bus.bloqueo !== 1'b0) begin n_fail++; $display("FAIL async_bloq: got %b expected 0", bus.bloqueo); end
        n_checks++; if (dut.state_q !== S_IDLE || bus.advertencia !== 1'b0) begin n_fail++; $display("FAIL async_state: got state=%0d adv=%b expected %0d 0", dut.state_q, bus.advertencia, S_IDLE); end
        @(negedge clk) rst = 1'b1;
        insert_card();
        enter_pin(16'h4756);
        press_stb();
        @(negedge clk);
        n_checks++; if (bus.pin_ok !== 1'b1) begin n_fail++; $display("FAIL after_reset_ok: got %b expected 1", bus.pin_ok); end
        $display("test_reset_locked done");
    endtask

    task automatic test_timeout();
        int seen;
        do_reset();
        insert_card();
        press(4'h4);
        seen = 0;
`ifdef PIN_TIMEOUT_EN
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.tiempo_agotado === 1'b1) begin seen = 1; break; end
        end
        n_checks++; if (seen != 1) begin n_fail++; $display("FAIL timeout_pulse: got %0d expected 1", seen); end
        n_checks++; if (dut.state_q !== S_IDLE || bus.digit_count !== 3'd0) begin n_fail++; $display("FAIL timeout_state: got state=%0d count=%0d expected %0d 0", dut.state_q, bus.digit_count, S_IDLE); end
        @(negedge clk);
        n_checks++; if (bus.tiempo_agotado !== 1'b0) begin n_fail++; $display("FAIL timeout_width: got %b expected 0", bus.tiempo_agotado); end
`else
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.tiempo_agotado !== 1'b0) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL no_timeout: got %0d pulses expected 0", seen); end
        n_checks++; if (dut.state_q !== S_COLLECT || bus.digit_count !== 3'd1) begin n_fail++; $display("FAIL no_timeout_state: got state=%0d count=%0d expected %0d 1", dut.state_q, bus.digit_count, S_COLLECT); end
`endif
        $display("test_timeout done");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.tarjeta_recibida = 1'b0;
        bus.add_digit  = 1'b0;
        bus.digito     = 4'h0;
        bus.digito_stb = 1'b0;
        bus.fin_sesion = 1'b0;
        bus.pin_ref    = 16'h4756;
        test_reset();
        test_correct_pin();
        test_fifth_digit();
        test_short_entry();
        test_stb_wins();
        test_lockout();
        test_reset_locked();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/atm_pin_ctrl.md
ATM_PIN_CTRL -- requirements
Module: atm_pin_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL provide: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: tarjeta_recibida  input  1  card inserted, starts session.
REQ-004 SHALL provide: add_digit  input  1  keypad digit strobe, level held for several cycles.
REQ-005 SHALL provide: digito  input  4  BCD digit, sampled with add_digit.
REQ-006 SHALL provide: digito_stb  input  1  "enter" key, requests PIN check.
REQ-007 SHALL provide: fin_sesion  input  1  session end from transaction controller.
REQ-008 SHALL provide: pin_ref  input  16  stored PIN, 4 BCD digits, first digit in [15:12].
REQ-009 SHALL provide: pin_ok  output  1  one-cycle pulse, PIN matched.
REQ-010 SHALL provide: pin_incorrecto  output  1  one-cycle pulse, failed attempt.
REQ-011 SHALL provide: advertencia  output  1  level, second failure recorded.
REQ-012 SHALL provide: bloqueo  output  1  level, card locked.
REQ-013 SHALL provide: digit_count  output  3  digits held in buffer, 0..4.
REQ-014 SHALL provide: tiempo_agotado  output  1  one-cycle pulse, entry timeout.

Function
REQ-015 SHALL implement states IDLE, COLLECT, CHECK, GRANTED, LOCKED.
REQ-016 IDLE: tarjeta_recibida=1 -> COLLECT next cycle, buffer and attempt counter cleared.
REQ-017 add_digit SHALL be rising-edge detected; one digit accepted per 0->1 transition regardless of hold length.
REQ-018 COLLECT: accepted digit shifts into 16-bit buffer from LSB side, digit_count increments; first digit ends in [15:12] after 4 digits.
REQ-019 Edges with digit_count=4 SHALL be ignored (no shift, no count change).
REQ-020 digito_stb=1 in COLLECT with digit_count=4 -> CHECK next cycle.
REQ-021 digito_stb=1 in COLLECT with digit_count<4 SHALL count as failed attempt (REQ-023 path, no CHECK state).
REQ-022 CHECK lasts exactly one cycle; buffer==pin_ref -> pin_ok pulse on following cycle, GRANTED.
REQ-023 Mismatch -> pin_incorrecto pulse, attempts+1 (2-bit saturating), buffer and digit_count cleared, back to COLLECT.
REQ-024 advertencia SHALL assert when attempts reaches 2 and hold until IDLE re-entered or reset.
REQ-025 Third failure -> bloqueo=1, LOCKED; LOCKED ignores all inputs, exits only by reset.
REQ-026 GRANTED: fin_sesion=1 -> IDLE; advertencia cleared.
REQ-027 add_digit edge and digito_stb in same cycle: digito_stb wins, digit discarded.
REQ-028 tarjeta_recibida outside IDLE SHALL be ignored; fin_sesion outside GRANTED ignored.
REQ-029 Outputs SHALL be registered; pin_ok/pin_incorrecto/tiempo_agotado never high more than one cycle.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, buffer=0, attempts=0, digit_count=0, all outputs 0, edge-detect register=0, timeout counter=0.
REQ-031 Reset mid-COLLECT, CHECK or LOCKED SHALL discard all progress; bloqueo cleared.

Configuration
REQ-032 Macro PIN_TIMEOUT_EN defined: 8-bit inactivity counter runs in COLLECT, cleared on each accepted digit; reaching 255 -> tiempo_agotado pulse, IDLE, buffer and attempts cleared.
REQ-033 PIN_TIMEOUT_EN undefined: no counter, tiempo_agotado tied 0, COLLECT waits indefinitely.

Verification
REQ-034 pin_ref=16'h4756, card, digits 4,7,5,6 (add_digit held 2 cycles each), digito_stb -> pin_ok pulse 2 cycles after stb, GRANTED, pin_incorrecto never high.
REQ-035 pin_ref=16'h4756, enter 1,2,3,4 + stb three times -> pin_incorrecto pulse each, advertencia=1 after 2nd, bloqueo=1 after 3rd, later correct PIN ignored.
REQ-036 Enter 4,7,5,6,9 then stb -> 5th digit ignored, digit_count stays 4, pin_ok.
REQ-037 Enter 4,7 then stb -> pin_incorrecto, digit_count=0, state COLLECT.
REQ-038 rst=0 asserted while LOCKED, between clock edges -> bloqueo=0 and state IDLE before next clk edge.
REQ-039 PIN_TIMEOUT_EN defined: card, one digit, idle 255 cycles -> tiempo_agotado pulse, IDLE; undefined: no pulse after 1000 cycles.
